// File: rtl/exp_series_seq.sv
// Sequential fixed-point e^x engine: one Taylor term per clock, operand and
// result exchanged over valid/ready handshakes.
module exp_series_seq #(
    parameter int WIDTH = 32,
    parameter int SCALE = 1000,
    parameter int TERMS = 20,
    parameter int CW    = $clog2(TERMS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic [CW-1:0]    iter_count
);

    localparam int PW = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] term_q;
    logic [WIDTH-1:0] sum_q;
    logic [CW-1:0]    i_q;
    logic [CW-1:0]    iter_q;
    logic             ovf_q;

    logic [PW-1:0]    prod;
    logic [PW-1:0]    div;
    logic [PW-1:0]    nt;
    logic [PW:0]      sum_ext;
    logic             nt_ovf;
    logic             last;

    function automatic logic exceeds(input logic [PW:0] v);
        return |v[PW:WIDTH];
    endfunction

    function automatic logic [WIDTH-1:0] saturate(input logic ovf, input logic [WIDTH-1:0] v);
        return ovf ? {WIDTH{1'b1}} : v;
    endfunction

    // Iteration datapath: next term and candidate sum at double width.
    always_comb begin
        prod    = PW'(term_q) * PW'(x_q);
        div     = PW'((i_q == '0) ? CW'(1) : i_q) * PW'(SCALE);
        nt      = prod / div;
        sum_ext = (PW+1)'(sum_q) + (PW+1)'(nt);
        // sum >= 0, so a sum that fits also guarantees the term itself fits
        nt_ovf  = exceeds(sum_ext);
        last    = (nt == '0) || (i_q == CW'(TERMS - 1));
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = CALC;
            CALC:    if (nt_ovf || last) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            x_q    <= '0;
            term_q <= '0;
            sum_q  <= '0;
            i_q    <= '0;
            iter_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x_q    <= x_in;
                        term_q <= WIDTH'(SCALE);
                        sum_q  <= WIDTH'(SCALE);
                        i_q    <= CW'(1);
                        ovf_q  <= 1'b0;
                    end
                end
                CALC: begin
                    iter_q <= i_q;
                    if (nt_ovf) begin
                        ovf_q <= 1'b1;
                    end else begin
                        term_q <= nt[WIDTH-1:0];
                        sum_q  <= sum_ext[WIDTH-1:0];
                        if (!last) i_q <= i_q + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready   = (state == IDLE);
    assign out_valid  = (state == DONE);
    assign result     = saturate(ovf_q, sum_q);
    assign overflow   = ovf_q;
    assign iter_count = iter_q;

endmodule

// File: tb/tb_exp_series_seq.sv
// Bench for exp_series_seq: Taylor-series reference model, per-cycle compare
// on the default instance, directed and random runs on small configurations.
module tb_exp_series_seq;

    localparam int SC = 1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] x_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        overflow;
    logic [4:0]  iter_count;

    logic        b_in_valid;
    logic [31:0] b_x;
    logic        b_out_ready;

    logic        w_in_ready, w_out_valid, w_ovf;
    logic [15:0] w_res;
    logic [4:0]  w_it;
    logic        f_in_ready, f_out_valid, f_ovf;
    logic [31:0] f_res;
    logic [1:0]  f_it;
    logic        t_in_ready, t_out_valid, t_ovf;
    logic [31:0] t_res;
    logic [0:0]  t_it;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    exp_series_seq u_def (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .overflow(overflow), .iter_count(iter_count)
    );

    exp_series_seq #(.WIDTH(16)) u_w16 (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(w_in_ready), .x_in(b_x[15:0]),
        .out_valid(w_out_valid), .out_ready(b_out_ready), .result(w_res),
        .overflow(w_ovf), .iter_count(w_it)
    );

    exp_series_seq #(.TERMS(4)) u_t4 (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(f_in_ready), .x_in(b_x),
        .out_valid(f_out_valid), .out_ready(b_out_ready), .result(f_res),
        .overflow(f_ovf), .iter_count(f_it)
    );

    exp_series_seq #(.TERMS(2)) u_t2 (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(t_in_ready), .x_in(b_x),
        .out_valid(t_out_valid), .out_ready(b_out_ready), .result(t_res),
        .overflow(t_ovf), .iter_count(t_it)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: sum the series term by term with exact wide integers.
    function automatic void model(input logic [63:0] x, input int w, input int terms,
                                  output logic [63:0] res, output bit ov, output int it);
        logic [127:0] term, sum, nt, mx;
        mx   = (128'd1 << w) - 128'd1;
        term = 128'(SC);
        sum  = 128'(SC);
        ov   = 1'b0;
        it   = 0;
        for (int i = 1; i < terms; i++) begin
            nt = (term * 128'(x)) / (128'(i) * 128'(SC));
            it = i;
            if (nt > mx || sum + nt > mx) begin
                ov = 1'b1;
                break;
            end
            term = nt;
            sum  = sum + nt;
            if (nt == 0) break;
        end
        res = ov ? mx[63:0] : sum[63:0];
    endfunction

    // Per-cycle compare of the default instance against a transaction-level model.
    bit          armed = 1'b0;
    bit          after_rst = 1'b0;
    bit          pending = 1'b0;
    int          age = 0;
    logic [63:0] m_res = '0;
    bit          m_ovf = 1'b0;
    int          m_it = 0;

    always @(negedge clk) begin
        bit exp_v;
        if (armed) begin
            if (after_rst) begin
                chk("rst_result", 64'(result), 64'd0);
                chk("rst_overflow", 64'(overflow), 64'd0);
                chk("rst_iter_count", 64'(iter_count), 64'd0);
                chk("rst_in_ready", 64'(in_ready), 64'd1);
                chk("rst_out_valid", 64'(out_valid), 64'd0);
            end else begin
                exp_v = pending && (age >= m_it);
                chk("in_ready", 64'(in_ready), 64'(!pending));
                chk("out_valid", 64'(out_valid), 64'(exp_v));
                if (exp_v) begin
                    chk("result", 64'(result), m_res);
                    chk("overflow", 64'(overflow), 64'(m_ovf));
                    chk("iter_count", 64'(iter_count), 64'(m_it));
                end
            end
        end
        after_rst = 1'b0;
        if (rst) begin
            armed     = 1'b1;
            after_rst = 1'b1;
            pending   = 1'b0;
        end else if (armed) begin
            if (!pending) begin
                if (in_valid) begin
                    pending = 1'b1;
                    age     = 0;
                    model(64'(x_in), 32, 20, m_res, m_ovf, m_it);
                end
            end else if (age >= m_it && out_ready) begin
                pending = 1'b0;
            end else if (age < 1000) begin
                age++;
            end
        end
    end

    task automatic send(input logic [31:0] x);
        int n = 0;
        in_valid = 1'b1;
        x_in     = x;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("send_wait_in_ready", 64'(n < 200), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic recv(input int hold, output logic [63:0] r, output bit ov, output int it);
        int n = 0;
        while (!out_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("recv_wait_out_valid", 64'(n < 200), 64'd1);
        r  = 64'(result);
        ov = overflow;
        it = int'(iter_count);
        repeat (hold) begin
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    // One operand into the three small configurations, checked cycle by cycle.
    task automatic b_run(input logic [31:0] x);
        logic [63:0] er[3];
        bit          eo[3];
        int          ei[3];
        logic [63:0] ar[3];
        bit          ao[3];
        int          ai[3];
        bit          av[3];
        model({48'd0, x[15:0]}, 16, 20, er[0], eo[0], ei[0]);
        model(64'(x), 32, 4, er[1], eo[1], ei[1]);
        model(64'(x), 32, 2, er[2], eo[2], ei[2]);
        b_in_valid = 1'b1;
        b_x        = x;
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            av[0] = w_out_valid; ar[0] = 64'(w_res); ao[0] = w_ovf; ai[0] = int'(w_it);
            av[1] = f_out_valid; ar[1] = 64'(f_res); ao[1] = f_ovf; ai[1] = int'(f_it);
            av[2] = t_out_valid; ar[2] = 64'(t_res); ao[2] = t_ovf; ai[2] = int'(t_it);
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("b%0d_out_valid", k), 64'(av[k]), 64'(c >= ei[k]));
                if (c == ei[k]) begin
                    chk($sformatf("b%0d_result", k), ar[k], er[k]);
                    chk($sformatf("b%0d_overflow", k), 64'(ao[k]), 64'(eo[k]));
                    chk($sformatf("b%0d_iter_count", k), 64'(ai[k]), 64'(ei[k]));
                end
            end
        end
        @(posedge clk); #1;
        b_out_ready = 1'b1;
        @(posedge clk); #1;
        b_out_ready = 1'b0;
        @(negedge clk);
        chk("b_in_ready_after", 64'({w_in_ready, f_in_ready, t_in_ready}), 64'd7);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] r;
        bit          ov;
        int          it;
        logic [31:0] x;

        rst = 1'b1; in_valid = 1'b0; x_in = '0; out_ready = 1'b0;
        b_in_valid = 1'b0; b_x = '0; b_out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Hand-computed pins on the model.
        model(64'd3000, 32, 20, r, ov, it);
        chk("pin_3000_res", r, 64'd20082); chk("pin_3000_it", 64'(it), 64'd13);
        model(64'd1000, 32, 20, r, ov, it);
        chk("pin_1000_res", r, 64'd2716); chk("pin_1000_it", 64'(it), 64'd7);
        model(64'd0, 32, 20, r, ov, it);
        chk("pin_0_res", r, 64'd1000); chk("pin_0_it", 64'(it), 64'd1);
        model(64'd20000, 16, 20, r, ov, it);
        chk("pin_w16_res", r, 64'hFFFF); chk("pin_w16_ovf", 64'(ov), 64'd1);
        chk("pin_w16_it", 64'(it), 64'd2);
        model(64'd3000, 32, 4, r, ov, it);
        chk("pin_t4_res", r, 64'd13000); chk("pin_t4_it", 64'(it), 64'd3);

        // Directed runs on the default instance.
        send(32'd3000); recv(0, r, ov, it);
        chk("d3000_res", r, 64'd20082); chk("d3000_it", 64'(it), 64'd13);
        send(32'd1000); recv(0, r, ov, it);
        chk("d1000_res", r, 64'd2716); chk("d1000_it", 64'(it), 64'd7);
        send(32'd0); recv(0, r, ov, it);
        chk("d0_res", r, 64'd1000); chk("d0_it", 64'(it), 64'd1);

        // Backpressure with an ignored operand offered while in DONE.
        send(32'd3000);
        for (int n = 0; n < 200 && !out_valid; n++) begin
            @(posedge clk); #1;
        end
        for (int k = 0; k < 5; k++) begin
            in_valid = (k < 2);
            x_in     = 32'd500;
            chk("bp_result", 64'(result), 64'd20082);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        recv(0, r, ov, it);
        chk("bp_final", r, 64'd20082);
        send(32'd1000); recv(0, r, ov, it);
        chk("b2b_1000", r, 64'd2716);
        send(32'd3000); recv(0, r, ov, it);
        chk("b2b_3000", r, 64'd20082);

        // Abort mid-calculation, then a clean transaction.
        send(32'd3000);
        repeat (4) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (15) begin
            @(posedge clk); #1;
        end
        chk("abort_no_out_valid", 64'(out_valid), 64'd0);
        send(32'd1000); recv(0, r, ov, it);
        chk("post_abort_1000", r, 64'd2716);

        // Random operands, including ones that saturate.
        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 3))
                0:       x = $urandom();
                1:       x = $urandom_range(14000, 20000);
                default: x = $urandom_range(0, 14000);
            endcase
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            send(x);
            recv($urandom_range(0, 3), r, ov, it);
        end

        // Small configurations.
        b_run(32'd20000);
        b_run(32'd3000);
        b_run(32'd0);
        b_run(32'hFFFF_FFFF);
        for (int k = 0; k < 12; k++) b_run($urandom_range(0, 60000));

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
